// File: rtl/alu_exec_stage_if.sv
// Handshake bundle for the ALU execute stage: request side (in_*) and result side (out_*).
// master drives requests and consumes results; slave is the execute stage itself.
interface alu_exec_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alucontrol;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [4:0]       rd;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic             out_zero;
    logic             out_illegal;
    logic [4:0]       out_rd;
    logic [CNT_W-1:0] illegal_count;

    modport master (
        output in_valid, alucontrol, op_a, op_b, rd, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_illegal, out_rd, illegal_count
    );

    modport slave (
        input  in_valid, alucontrol, op_a, op_b, rd, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_illegal, out_rd, illegal_count
    );
endinterface

// File: rtl/alu_exec_stage.sv
// ALU execute stage: registered result/zero/illegal outputs behind valid/ready handshakes,
// with a one-entry skid buffer so full throughput survives downstream backpressure.
module alu_exec_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    alu_exec_stage_if.slave bus
);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110
    } alu_op_e;

    typedef struct packed {
        logic [3:0]      code;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
    } op_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    op_t              in_op;
    op_t              src_op;
    op_t              skid_op;
    logic             skid_valid;
    logic             skid_next;
    logic             in_ready_q;

    logic             out_valid_q;
    logic [XLEN-1:0]  out_result_q;
    logic             out_zero_q;
    logic             out_illegal_q;
    logic [4:0]       out_rd_q;
    logic [CNT_W-1:0] illegal_count_q;

    logic             accept;
    logic             can_load;
    logic             handoff;
    logic             src_valid;
    logic [XLEN-1:0]  alu_result;
    logic             alu_illegal;
    logic             alu_zero;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        in_op       = '{code: bus.alucontrol, a: bus.op_a, b: bus.op_b, rd: bus.rd};
        accept      = bus.in_valid && in_ready_q;
        can_load    = !out_valid_q || bus.out_ready;
        handoff     = out_valid_q && bus.out_ready;
        src_valid   = skid_valid || accept;
        src_op      = skid_valid ? skid_op : in_op;
        alu_result  = '0;
        alu_illegal = 1'b0;

        case (src_op.code)
            OP_AND:  alu_result = src_op.a & src_op.b;
            OP_OR:   alu_result = src_op.a | src_op.b;
            OP_ADD:  alu_result = src_op.a + src_op.b;
            OP_SUB:  alu_result = src_op.a - src_op.b;
            default: alu_illegal = 1'b1;
        endcase

        // An illegal op reports zero=0 even though its result is forced to 0.
        alu_zero = !alu_illegal && (alu_result == '0);

        skid_next = skid_valid;
        if (skid_valid && can_load) begin
            skid_next = 1'b0;
        end else if (accept && !can_load) begin
            skid_next = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_valid      <= 1'b0;
            in_ready_q      <= 1'b0;
            out_valid_q     <= 1'b0;
            out_result_q    <= '0;
            out_zero_q      <= 1'b0;
            out_illegal_q   <= 1'b0;
            out_rd_q        <= '0;
            illegal_count_q <= '0;
        end else begin
            skid_valid <= skid_next;
            in_ready_q <= !skid_next;

            if (can_load) begin
                out_valid_q <= src_valid;
                if (src_valid) begin
                    out_result_q  <= alu_result;
                    out_zero_q    <= alu_zero;
                    out_illegal_q <= alu_illegal;
                    out_rd_q      <= src_op.rd;
                end
            end

            if (handoff && out_illegal_q && (illegal_count_q != '1)) begin
                illegal_count_q <= illegal_count_q + CNT_ONE;
            end
        end
    end

    // NOTE: the skid payload carries no reset; skid_valid alone says whether it means anything.
    always_ff @(posedge clk) begin
        if (accept && !can_load) begin
            skid_op <= in_op;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_result    = out_result_q;
    assign bus.out_zero      = out_zero_q;
    assign bus.out_illegal   = out_illegal_q;
    assign bus.out_rd        = out_rd_q;
    assign bus.illegal_count = illegal_count_q;

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage that sits directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code together with two operands and a destination tag.
- Performs the operation and presents a registered result, zero flag and illegal-op flag to the next stage.
- Valid/ready handshakes on both sides, with a one-entry skid buffer, so it sustains one op per cycle under backpressure.

Parameters:
- XLEN, 32, operand/result width in bits.
- CNT_W, 16, width of the saturating illegal-op counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  upstream holds a valid op.
- in_ready  out  1  stage can accept an op this cycle.
- alucontrol  in  4  ALU code from the shared header: AND=4'b0000, OR=4'b0001, ADD=4'b0010, SUB=4'b0110, INVALID=4'b1111.
- op_a  in  XLEN  first operand.
- op_b  in  XLEN  second operand.
- rd  in  5  destination tag, carried through unchanged.
- out_valid  out  1  result registers hold a valid op.
- out_ready  in  1  downstream accepts the result.
- out_result  out  XLEN  operation result.
- out_zero  out  1  out_result == 0 (used for branch compare).
- out_illegal  out  1  op code was not one of the four legal codes.
- out_rd  out  5  tag of the result.
- illegal_count  out  CNT_W  count of illegal ops delivered downstream.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n, sampled at the rising edge.
- Reset values: out_valid=0, out_result=0, out_zero=0, out_illegal=0, out_rd=0, illegal_count=0, skid empty, in_ready=0 while rst_n=0. in_ready=1 in the first cycle after reset releases.
- Input accept: an op is accepted when in_valid && in_ready. in_ready is a register and equals !skid_full.
- Output handoff: a result is delivered when out_valid && out_ready.
- Output register load: the output register may load when !out_valid || out_ready. Source is the skid entry if occupied, else the accepted input op.
- Skid fill: if an op is accepted while the output register cannot load, it goes into the skid entry and in_ready drops next cycle.
- Skid drain: the skid entry moves to the output register on the next load opportunity. in_ready returns to 1 the cycle after.
- Latency: an op accepted at edge N appears on the outputs after edge N (out_valid high in cycle N+1). Throughput is 1 op/cycle when out_ready stays 1.
- Ordering: strict FIFO. Every accepted op is delivered exactly once; none are dropped or duplicated.
- Arithmetic: computed on the registered source operands.
  - ADD = op_a + op_b mod 2^XLEN.
  - SUB = op_a - op_b mod 2^XLEN (two's complement, wraps; no overflow flag).
  - AND and OR are bitwise.
- Zero flag: out_zero = (out_result == 0), registered with the result.
- Illegal codes (INVALID or any unlisted code): out_result=0, out_zero=0, out_illegal=1, out_rd passes through. The op still flows through the handshake.
- illegal_count: increments by 1 on each handoff with out_illegal=1. Saturates at 2^CNT_W-1 (no wrap).
- Stall: while out_valid && !out_ready, all out_* hold stable.
- Simultaneous events:
  - Handoff and new accept in the same cycle with an empty skid: the output loads directly, with no bubble.
  - Skid full and out_ready=1: the skid drains and no input is accepted that cycle, since in_ready=0.
- Reset mid-operation: any in-flight output or skid entry is discarded, out_valid=0 the next cycle, and the counter clears.
- Input signals are don't-care when in_valid=0. Outputs other than out_valid are don't-care when out_valid=0, but reset still forces them to 0.

Test Plan:
- Reset, then back-to-back ops with out_ready=1:
  - ADD 5+7 -> result 12, zero 0, one cycle later.
  - SUB 9-9 -> result 0, zero 1.
  - AND 0xF0F0&0xFF00 -> 0xF000.
  - OR 0x0F|0xF0 -> 0xFF.
  - Expect one result per cycle, in order.
- SUB 0-1 -> out_result 0xFFFFFFFF, zero 0.
- ADD 0xFFFFFFFF+1 -> 0x00000000, zero 1.
- Hold out_ready=0 while issuing 3 ops:
  - First op is held stable on the outputs; the second is captured in the skid.
  - in_ready drops; the third is not accepted until out_ready rises.
  - All 3 are delivered in order with correct rd tags.
- Codes INVALID and 4'b0101 -> out_illegal=1, result 0, zero 0; illegal_count reaches 2 after both handoffs.
- Force illegal_count to the maximum via 65535 illegal ops (CNT_W=16), then one more -> the count stays at 0xFFFF.
- Assert rst_n=0 for one cycle with the skid full and out_valid=1 -> next cycle out_valid=0 and illegal_count=0. No stale op emerges after reset; the next op issued is delivered correctly.
